// File: rtl/fp_div_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_div_if : operand/result handshake bundle for the binary32 divider     |
// | Revision  : 1.0                                                         |
// +-------------------------------------------------------------------------+
interface fp_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        dz;
  logic        nv;

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf, dz, nv
  );

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf, dz, nv
  );
endinterface
`default_nettype wire

// File: rtl/fp_div_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fp_div_seq : sequential binary32 divider, radix-2 restoring, 1 bit/cycle |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input wire     clk,
  input wire     rst_n,
  fp_div_if.slave bus
);

  localparam int QB    = FRC_W + 4;
  localparam int MW    = FRC_W + 1;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(QB);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int W     = 1 + EXP_W + FRC_W;

  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EW-1:0]    E_OVF     = EW'((1 << EXP_W) - 1);
  localparam logic [W-2:0]     MAG_INF   = {EXP_ONES, {FRC_W{1'b0}}};
  localparam logic [W-2:0]     MAG_MAX   = {{(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(FRC_W-1){1'b0}}};

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [2:0]       mode_q, mode_d;
  logic [EW-1:0]    exp_q, exp_d;
  logic [MW-1:0]    my_q, my_d;
  logic [MW:0]      rem_q, rem_d;
  logic [QB-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     z_q, z_d;
  logic             ovrf_q, ovrf_d, udrf_q, udrf_d, dz_q, dz_d, nv_q, nv_d;
  logic             out_valid_q, out_valid_d;

  // Operand field decode; exponent zero covers both zero and subnormal (flushed).
  logic [EXP_W-1:0] w_ex, w_ey;
  logic [FRC_W-1:0] w_fx, w_fy;
  logic             w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan, w_sign;

  assign w_ex     = bus.fp_X[W-2 -: EXP_W];
  assign w_ey     = bus.fp_Y[W-2 -: EXP_W];
  assign w_fx     = bus.fp_X[FRC_W-1:0];
  assign w_fy     = bus.fp_Y[FRC_W-1:0];
  assign w_sign   = bus.fp_X[W-1] ^ bus.fp_Y[W-1];
  assign w_x_zero = (w_ex == '0);
  assign w_y_zero = (w_ey == '0);
  assign w_x_inf  = (w_ex == EXP_ONES) && (w_fx == '0);
  assign w_y_inf  = (w_ey == EXP_ONES) && (w_fy == '0);
  assign w_x_nan  = (w_ex == EXP_ONES) && (w_fx != '0);
  assign w_y_nan  = (w_ey == EXP_ONES) && (w_fy != '0);

  // One restoring step: remainder always fits MW bits after a successful subtract.
  logic          w_qbit;
  logic [MW-1:0] w_rem_keep;

  assign w_qbit     = (rem_q >= {1'b0, my_q});
  assign w_rem_keep = w_qbit ? MW'(rem_q - {1'b0, my_q}) : rem_q[MW-1:0];

  logic [FRC_W-1:0] w_frac;
  logic             w_g, w_s, w_inc;
  logic [EW-1:0]    w_e, w_e_rnd;
  logic [FRC_W:0]   w_sum;
  logic             w_ovf, w_udf;
  logic [W-2:0]     w_ovf_mag;

  always_comb begin
    if (quo_q[QB-1]) begin
      w_frac = quo_q[QB-2:3];
      w_g    = quo_q[2];
      w_s    = (|quo_q[1:0]) | (|rem_q);
      w_e    = exp_q;
    end else begin
      w_frac = quo_q[QB-3:2];
      w_g    = quo_q[1];
      w_s    = quo_q[0] | (|rem_q);
      w_e    = exp_q - EW'(1);
    end

    case (mode_q)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = sign_q & (w_g | w_s);
      RM_RUP:  w_inc = ~sign_q & (w_g | w_s);
      RM_RMM:  w_inc = w_g;
      default: w_inc = w_g & (w_s | w_frac[0]);
    endcase

    w_sum   = {1'b0, w_frac} + {{FRC_W{1'b0}}, w_inc};
    w_e_rnd = w_sum[FRC_W] ? (w_e + EW'(1)) : w_e;
    w_ovf   = ~w_e_rnd[EW-1] && (w_e_rnd >= E_OVF);
    w_udf   = w_e_rnd[EW-1] || (w_e_rnd == '0);

    case (mode_q)
      RM_RTZ:  w_ovf_mag = MAG_MAX;
      RM_RDN:  w_ovf_mag = sign_q ? MAG_INF : MAG_MAX;
      RM_RUP:  w_ovf_mag = sign_q ? MAG_MAX : MAG_INF;
      default: w_ovf_mag = MAG_INF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mode_d      = mode_q;
    exp_d       = exp_q;
    my_d        = my_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    z_d         = z_q;
    ovrf_d      = ovrf_q;
    udrf_d      = udrf_q;
    dz_d        = dz_q;
    nv_d        = nv_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_d  = w_sign;
          mode_d  = (bus.r_mode > RM_RMM) ? RM_RNE : bus.r_mode;
          exp_d   = {2'b00, w_ex} - {2'b00, w_ey} + EW'(BIAS);
          my_d    = {1'b1, w_fy};
          rem_d   = {2'b01, w_fx};
          quo_d   = '0;
          cnt_d   = CNT_W'(QB - 1);
          z_d     = '0;
          ovrf_d  = 1'b0;
          udrf_d  = 1'b0;
          dz_d    = 1'b0;
          nv_d    = 1'b0;
          state_d = S_DONE;
          if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
            z_d  = QNAN;
            nv_d = 1'b1;
          end else if (w_x_inf) begin
            z_d = {w_sign, MAG_INF};
          end else if (w_y_zero) begin
            z_d  = {w_sign, MAG_INF};
            dz_d = 1'b1;
          end else if (w_x_zero || w_y_inf) begin
            z_d = {w_sign, {(W-1){1'b0}}};
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        quo_d = {quo_q[QB-2:0], w_qbit};
        rem_d = {w_rem_keep, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (w_ovf) begin
          z_d    = {sign_q, w_ovf_mag};
          ovrf_d = 1'b1;
        end else if (w_udf) begin
          z_d    = {sign_q, {(W-1){1'b0}}};
          udrf_d = 1'b1;
        end else begin
          z_d = {sign_q, w_e_rnd[EXP_W-1:0], w_sum[FRC_W-1:0]};
        end
        state_d = S_DONE;
      end
      default: begin
        // First DONE cycle raises out_valid; the result registers are already settled.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      mode_q      <= '0;
      exp_q       <= '0;
      my_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      z_q         <= '0;
      ovrf_q      <= 1'b0;
      udrf_q      <= 1'b0;
      dz_q        <= 1'b0;
      nv_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mode_q      <= mode_d;
      exp_q       <= exp_d;
      my_q        <= my_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      ovrf_q      <= ovrf_d;
      udrf_q      <= udrf_d;
      dz_q        <= dz_d;
      nv_q        <= nv_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.fp_Z      = z_q;
  assign bus.ovrf      = ovrf_q;
  assign bus.udrf      = udrf_q;
  assign bus.dz        = dz_q;
  assign bus.nv        = nv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fp_div_seq : directed vectors with hand-computed results for divider  |
// | Revision      : 1.0                                                     |
// +-------------------------------------------------------------------------+
module tb_fp_div_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  fp_div_if bus ();

  fp_div_seq #(.EXP_W(8), .FRC_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Flags are packed {ovrf, udrf, dz, nv}.
  logic [31:0] rnd_x [0:7] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                               32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000};
  logic [2:0]  rnd_m [0:7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd2, 3'd3};
  logic [31:0] rnd_z [0:7] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAA, 32'h3EAAAAAB,
                               32'h3EAAAAAB, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hBEAAAAAA};

  logic [31:0] sp_x [0:7]  = '{32'h40490FDB, 32'h00000000, 32'h002DF854, 32'h7F800000,
                               32'h40000000, 32'h7FC00001, 32'h7F800000, 32'hC0400000};
  logic [31:0] sp_y [0:7]  = '{32'h00000000, 32'h00000000, 32'h40490FDB, 32'h40000000,
                               32'hFF800000, 32'h3F800000, 32'hFF800000, 32'h00000000};
  logic [31:0] sp_z [0:7]  = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7F800000,
                               32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};
  logic [3:0]  sp_f [0:7]  = '{4'b0010, 4'b0001, 4'b0000, 4'b0000,
                               4'b0000, 4'b0001, 4'b0001, 4'b0010};

  logic [31:0] ov_x [0:6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF,
                               32'h7F7FFFFF, 32'h00800000, 32'h80800000};
  logic [31:0] ov_y [0:6]  = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                               32'h3F000000, 32'h40000000, 32'h40000000};
  logic [2:0]  ov_m [0:6]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd0, 3'd3};
  logic [31:0] ov_z [0:6]  = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'hFF7FFFFF,
                               32'h7F7FFFFF, 32'h00000000, 32'h80000000};
  logic [3:0]  ov_f [0:6]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b1000, 4'b0100, 4'b0100};

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    for (int n = 0; n < 40 && bus.in_ready !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.fp_X     = x;
    bus.fp_Y     = y;
    bus.r_mode   = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.fp_X     = 32'hDEADBEEF;
    bus.fp_Y     = 32'h12345678;
    bus.r_mode   = 3'd3;
  endtask

  task automatic wait_result(output logic [31:0] z, output logic [3:0] fl, output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    z  = bus.fp_Z;
    fl = {bus.ovrf, bus.udrf, bus.dz, bus.nv};
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                        output logic [31:0] z, output logic [3:0] fl, output int lat);
    send(x, y, m);
    wait_result(z, fl, lat);
    release_out();
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    vectors++; if (bus.fp_Z !== 32'h0) begin miscompares++; $display("FAIL reset_fp_Z: got %h expected 00000000", bus.fp_Z); end
    vectors++; if ({bus.ovrf, bus.udrf, bus.dz, bus.nv} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", {bus.ovrf, bus.udrf, bus.dz, bus.nv}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] z; logic [3:0] fl; int lat;
    run_op(32'h41100000, 32'h40400000, 3'd1, z, fl, lat);
    vectors++; if (z !== 32'h40400000) begin miscompares++; $display("FAIL basic_9div3 fp_Z: got %h expected 40400000", z); end
    vectors++; if (fl !== 4'b0) begin miscompares++; $display("FAIL basic_9div3 flags: got %b expected 0000", fl); end
    vectors++; if (lat !== 29) begin miscompares++; $display("FAIL basic_9div3 latency: got %0d expected 29", lat); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drop_valid: got %b expected 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_back: got %b expected 1", bus.in_ready); end
    run_op(32'hC1100000, 32'h40400000, 3'd1, z, fl, lat);
    vectors++; if (z !== 32'hC0400000) begin miscompares++; $display("FAIL basic_neg9div3 fp_Z: got %h expected C0400000", z); end
  endtask

  task automatic test_rounding();
    logic [31:0] z; logic [3:0] fl; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(rnd_x[i], 32'h40400000, rnd_m[i], z, fl, lat);
      vectors++; if (z !== rnd_z[i]) begin miscompares++; $display("FAIL round[%0d] fp_Z: got %h expected %h", i, z, rnd_z[i]); end
      vectors++; if (fl !== 4'b0) begin miscompares++; $display("FAIL round[%0d] flags: got %b expected 0000", i, fl); end
    end
  endtask

  task automatic test_special();
    logic [31:0] z; logic [3:0] fl; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(sp_x[i], sp_y[i], 3'd0, z, fl, lat);
      vectors++; if (z !== sp_z[i]) begin miscompares++; $display("FAIL special[%0d] fp_Z: got %h expected %h", i, z, sp_z[i]); end
      vectors++; if (fl !== sp_f[i]) begin miscompares++; $display("FAIL special[%0d] flags: got %b expected %b", i, fl, sp_f[i]); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL special[%0d] latency: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] z; logic [3:0] fl; int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(ov_x[i], ov_y[i], ov_m[i], z, fl, lat);
      vectors++; if (z !== ov_z[i]) begin miscompares++; $display("FAIL range[%0d] fp_Z: got %h expected %h", i, z, ov_z[i]); end
      vectors++; if (fl !== ov_f[i]) begin miscompares++; $display("FAIL range[%0d] flags: got %b expected %b", i, fl, ov_f[i]); end
      vectors++; if (lat !== 29) begin miscompares++; $display("FAIL range[%0d] latency: got %0d expected 29", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z; logic [3:0] fl; int lat;
    send(32'h41100000, 32'h40400000, 3'd1);
    wait_result(z, fl, lat);
    bus.in_valid = 1'b1;
    bus.fp_X     = 32'h3F800000;
    bus.fp_Y     = 32'h40400000;
    bus.r_mode   = 3'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall[%0d] out_valid: got %b expected 1", c, bus.out_valid); end
      vectors++; if (bus.fp_Z !== 32'h40400000) begin miscompares++; $display("FAIL stall[%0d] fp_Z: got %h expected 40400000", c, bus.fp_Z); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall[%0d] in_ready: got %b expected 0", c, bus.in_ready); end
      vectors++; if ({bus.ovrf, bus.udrf, bus.dz, bus.nv} !== 4'b0) begin miscompares++; $display("FAIL stall[%0d] flags: got %b expected 0000", c, {bus.ovrf, bus.udrf, bus.dz, bus.nv}); end
    end
    release_out();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL handshake out_valid: got %b expected 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL handshake in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL held_accept in_ready: got %b expected 0", bus.in_ready); end
    wait_result(z, fl, lat);
    release_out();
    vectors++; if (z !== 32'h3EAAAAAB) begin miscompares++; $display("FAIL held_op fp_Z: got %h expected 3EAAAAAB", z); end
    vectors++; if (lat !== 29) begin miscompares++; $display("FAIL held_op latency: got %0d expected 29", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z; logic [3:0] fl; int lat;
    send(32'h3F800000, 32'h40400000, 3'd0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset out_valid: got %b expected 0", bus.out_valid); end
    vectors++; if (bus.fp_Z !== 32'h0) begin miscompares++; $display("FAIL midreset fp_Z: got %h expected 00000000", bus.fp_Z); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL postreset in_ready: got %b expected 1", bus.in_ready); end
    run_op(32'h41100000, 32'h40400000, 3'd1, z, fl, lat);
    vectors++; if (z !== 32'h40400000) begin miscompares++; $display("FAIL postreset fp_Z: got %h expected 40400000", z); end
    vectors++; if (lat !== 29) begin miscompares++; $display("FAIL postreset latency: got %0d expected 29", lat); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fp_X      = 32'h0;
    bus.fp_Y      = 32'h0;
    bus.r_mode    = 3'd0;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
